common_clock_fifo_a2: RTL

COMMON_CLOCK_FIFO_A2 -- requirements
Module: common_clock_fifo_a2

---
 rtl/common_clock_fifo_a2.sv | 109 ++++++++++
 1 files changed

// File: rtl/common_clock_fifo_a2.sv
// Single-clock FIFO with registered status flags, selectable standard or
// first-word-fall-through read mode, and overflow/underflow pulses.
module common_clock_fifo_a2 #(
  parameter int               DEPTH      = 8,
  parameter int               DSIZE      = 8,
  parameter logic [DSIZE-1:0] INIT_VALUE = '0,
  parameter bit               FWFT       = 1'b1,
  parameter int               AFULL_TH   = DEPTH - 1,
  parameter int               AEMPTY_TH  = 1,
  parameter int               CSIZE      = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rdata,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CSIZE-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || DSIZE < 1 || AFULL_TH < 1 || AFULL_TH > DEPTH ||
      AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1 || CSIZE != $clog2(DEPTH + 1)) begin : g_bad_params
    $fatal(1, "common_clock_fifo_a2: parameter out of legal range");
  end

  logic [DSIZE-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CSIZE-1:0] mem_count, mem_count_next, count_next;
  logic             tap_valid, tap_valid_next;
  logic             wr_acc, rd_acc, mem_wr, mem_rd, bypass, empty_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // In FWFT mode the tap register holds the head word; mem_count excludes it.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_acc         = wr_en && !full;
    rd_acc         = rd_en && !empty;
    bypass         = 1'b0;
    mem_rd         = 1'b0;
    tap_valid_next = 1'b0;
    if (FWFT) begin
      // Popping the last word while writing feeds the tap directly, avoiding a bubble.
      bypass         = wr_acc && rd_acc && (mem_count == '0);
      mem_rd         = (mem_count != '0) && (!tap_valid || rd_acc);
      tap_valid_next = bypass || mem_rd || (tap_valid && !rd_acc);
    end else begin
      mem_rd = rd_acc;
    end
    mem_wr         = wr_acc && !bypass;
    count_next     = count + CSIZE'(wr_acc) - CSIZE'(rd_acc);
    mem_count_next = mem_count + CSIZE'(mem_wr) - CSIZE'(mem_rd);
    empty_next     = FWFT ? !tap_valid_next : (count_next == '0);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      mem_count    <= '0;
      count        <= '0;
      tap_valid    <= 1'b0;
      rdata        <= INIT_VALUE;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      // NOTE: the storage array is reset explicitly because its contents are
      // observable through rdata; this costs a flop-based array, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VALUE;
    end else begin
      if (mem_wr) begin
        mem[wptr] <= wdata;
        wptr      <= ptr_inc(wptr);
      end
      if (mem_rd) begin
        rdata <= mem[rptr];
        rptr  <= ptr_inc(rptr);
      end else if (bypass) begin
        rdata <= wdata;
      end
      mem_count    <= mem_count_next;
      count        <= count_next;
      tap_valid    <= tap_valid_next;
      empty        <= empty_next;
      full         <= (count_next == CSIZE'(DEPTH));
      almost_full  <= (int'(count_next) >= AFULL_TH);
      almost_empty <= (int'(count_next) <= AEMPTY_TH);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
    end
  end

endmodule
